// File: rtl/arbiter_pkg.sv
// Shared arbitration types and the circular priority search used by the arbiter library.
package arbiter_pkg;

  typedef enum logic [0:0] {IDLE, LOCKED} arb_state_t;

  // Widest request vector the shared search supports.
  localparam int unsigned MaxPort = 32;
  localparam int unsigned MaxIdxW = 5;

  // One-hot pick of the first set bit of req[n-1:0], searching upward (mod n) from ptr+1.
  // Returns zero when no request is set.
  function automatic logic [MaxPort-1:0] rr_pick(input logic [MaxPort-1:0] req,
                                                 input int unsigned         ptr,
                                                 input int unsigned         n);
    logic [MaxPort-1:0] pick;
    logic               found;
    logic [MaxIdxW-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= MaxPort; off++) begin
      if (off <= n) begin
        idx = MaxIdxW'((ptr + off) % n);
        if (!found && req[idx]) begin
          pick[idx] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Combinational round-robin pick: first request above ptr_i (wrapping), one-hot result.
module rr_pick_onehot
  import arbiter_pkg::*;
#(
  parameter int unsigned Port = 4,
  parameter int unsigned IdxW = (Port > 1) ? $clog2(Port) : 1
) (
  input  logic [Port-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [Port-1:0] pick_o
);

  logic [MaxPort-1:0] req_ext;
  logic [MaxPort-1:0] pick_ext;

  assign req_ext  = MaxPort'(req_i);
  assign pick_ext = rr_pick(req_ext, 32'(ptr_i), Port);
  assign pick_o   = pick_ext[Port-1:0];

  // Bits above Port can never be picked because their requests are tied to zero.
  if (Port < MaxPort) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^pick_ext[MaxPort-1:Port];
  end

endmodule

// File: rtl/arbiter_wrr_packet.sv
// Packet-aware weighted round-robin arbiter: grant held for a whole packet, up to
// cfg_weight consecutive packets per port before priority moves on.
module arbiter_wrr_packet
  import arbiter_pkg::*;
#(
  parameter int unsigned Port    = 4,
  parameter int unsigned Width   = 32,
  parameter int unsigned WeightW = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [Port-1:0][WeightW-1:0]    cfg_weight,
  input  logic [Port-1:0]                 in_valid,
  input  logic [Port-1:0]                 in_last,
  input  logic [Port-1:0][Width-1:0]      in_data,
  output logic [Port-1:0]                 in_ready,
  output logic                            out_valid,
  output logic                            out_last,
  output logic [Width-1:0]                out_data,
  output logic [Port-1:0]                 out_src,
  input  logic                            out_ready
);

  localparam int unsigned IdxW = (Port > 1) ? $clog2(Port) : 1;
  typedef logic [IdxW-1:0] idx_t;

  arb_state_t         state_q, state_d;
  idx_t               ptr_q, ptr_d;
  idx_t               cur_q, cur_d;
  idx_t               owner_q, owner_d;
  logic [WeightW-1:0] credit_q, credit_d;

  logic [Port-1:0]    pick_oh;
  idx_t               pick_idx;
  idx_t               sel;
  logic               sel_act;
  logic               eop;
  logic               reload;
  logic [WeightW-1:0] w_sel;
  logic [WeightW-1:0] credit_eff;

  rr_pick_onehot #(
    .Port (Port),
    .IdxW (IdxW)
  ) u_pick (
    .req_i  (in_valid),
    .ptr_i  (ptr_q),
    .pick_o (pick_oh)
  );

  // Encode the one-hot pick to a port index.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < Port; i++) begin
      if (pick_oh[i]) pick_idx = idx_t'(i);
    end
  end

  // Zero-latency pass-through from the selected port; everything quiet while in reset.
  always_comb begin
    sel       = (state_q == LOCKED) ? cur_q : pick_idx;
    sel_act   = !rst && ((state_q == LOCKED) || (|in_valid));
    out_valid = sel_act && in_valid[sel];
    out_last  = sel_act && in_last[sel];
    out_data  = sel_act ? in_data[sel] : '0;
    out_src   = '0;
    in_ready  = '0;
    if (out_valid) out_src[sel] = 1'b1;
    if (sel_act)   in_ready[sel] = out_ready;
  end

  // Lock FSM, credit reload/consume and priority pointer update.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    eop      = out_valid && out_ready && in_last[sel];
    reload   = (state_q == IDLE) && (|in_valid) && (pick_idx != owner_q);
    w_sel    = cfg_weight[sel];
    // A zero weight still grants one packet per turn.
    credit_eff = credit_q;
    if (reload) begin
      credit_eff = (w_sel == '0) ? '0 : w_sel - WeightW'(1);
      owner_d    = sel;
    end
    credit_d = credit_eff;

    unique case (state_q)
      IDLE: begin
        if ((|in_valid) && !eop) begin
          state_d = LOCKED;
          cur_d   = sel;
        end
      end
      LOCKED: begin
        if (eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (eop) begin
      if (credit_eff == '0) begin
        ptr_d = sel;
      end else begin
        // Point just below the port so it stays first in line for the next pick only.
        ptr_d    = (sel == '0) ? idx_t'(Port - 1) : sel - idx_t'(1);
        credit_d = credit_eff - WeightW'(1);
      end
    end
  end

  // State registers; reset leaves port 0 as the first winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= idx_t'(Port - 1);
      cur_q    <= '0;
      owner_q  <= idx_t'(Port - 1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));

  a_data_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> $stable(out_data));

  a_src_locked : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !(out_ready && out_last)) |=> (out_src == '0 || out_src == $past(out_src)));

endmodule

// File: tb/tb_arbiter_wrr_packet.sv
// Self-checking bench: combinational vector table plus packet-level scoreboard sequences.
module tb_arbiter_wrr_packet;

  localparam int Port    = 4;
  localparam int Width   = 32;
  localparam int WeightW = 4;

  logic                         clk;
  logic                         rst;
  logic [Port-1:0][WeightW-1:0] cfg_weight;
  logic [Port-1:0]              in_valid;
  logic [Port-1:0]              in_last;
  logic [Port-1:0][Width-1:0]   in_data;
  logic [Port-1:0]              in_ready;
  logic                         out_valid;
  logic                         out_last;
  logic [Width-1:0]             out_data;
  logic [Port-1:0]              out_src;
  logic                         out_ready;

  arbiter_wrr_packet #(
    .Port    (Port),
    .Width   (Width),
    .WeightW (WeightW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_weight (cfg_weight),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             r;
    logic [Port-1:0]  v;
    logic [Port-1:0]  l;
    logic             rdy;
    logic             ev;
    logic             el;
    logic [Port-1:0]  esrc;
    logic [Port-1:0]  erdy;
    logic [Width-1:0] edata;
  } vec_t;

  typedef struct {
    logic [Width-1:0] data;
    logic             last;
  } beat_t;

  typedef struct {
    logic [Port-1:0]  src;
    logic [Width-1:0] data;
    logic             last;
  } exp_t;

  int    n_checks;
  int    n_fail;
  vec_t  tbl [7];
  beat_t pq [Port][$];
  exp_t  sb [$];
  bit    rpat [$];
  int    ord [$];

  function automatic vec_t mkv(input logic r, input logic [Port-1:0] v, input logic [Port-1:0] l,
                               input logic rdy, input logic ev, input logic el,
                               input logic [Port-1:0] esrc, input logic [Port-1:0] erdy,
                               input logic [Width-1:0] edata);
    vec_t x;
    x.r = r; x.v = v; x.l = l; x.rdy = rdy; x.ev = ev; x.el = el;
    x.esrc = esrc; x.erdy = erdy; x.edata = edata;
    return x;
  endfunction

  function automatic logic [Width-1:0] mk_data(input int p, input int k, input int b);
    return {8'(p), 8'(k), 8'(b), 8'hA5};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < Port; i++) begin
      if (pq[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_data[i]  = pq[i][0].data;
        in_last[i]  = pq[i][0].last;
      end else begin
        in_valid[i] = 1'b0;
        in_data[i]  = '0;
        in_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic load_pkt(input int p, input int k, input int nb);
    beat_t bt;
    for (int b = 0; b < nb; b++) begin
      bt.data = mk_data(p, k, b);
      bt.last = (b == nb - 1);
      pq[p].push_back(bt);
    end
  endtask

  task automatic exp_pkt(input int p, input int k, input int nb, input int first_b);
    exp_t e;
    for (int b = first_b; b < nb; b++) begin
      e.src  = Port'(1) << p;
      e.data = mk_data(p, k, b);
      e.last = (b == nb - 1);
      sb.push_back(e);
    end
  endtask

  // Expected single-beat packet order, numbering each port's packets from 0.
  task automatic expect_order();
    int cnt [Port];
    for (int i = 0; i < Port; i++) cnt[i] = 0;
    foreach (ord[j]) begin
      exp_pkt(ord[j], cnt[ord[j]], 1, 0);
      cnt[ord[j]]++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < Port; i++) pq[i].delete();
    sb.delete();
    drive();
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Run until the scoreboard drains or max_cyc elapses; checks every accepted beat in order,
  // stall stability, and the total cycle count.
  task automatic run(input string tag, input int max_cyc, input int exp_cyc,
                     input int chg_cyc, input logic [WeightW-1:0] chg_w0);
    int              cyc;
    logic [Port-1:0] acc;
    bit              stalled;
    logic [Width-1:0] held;
    exp_t            e;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    out_ready = rpat[0];
    drive();
    while (cyc < max_cyc) begin
      @(negedge clk);
      if (stalled && out_valid) check({tag, " stall data"}, out_data, held);
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s unexpected beat: got src %0h data %0h expected none",
                   tag, out_src, out_data);
        end else begin
          e = sb.pop_front();
          check({tag, " src"}, out_src, e.src);
          check({tag, " data"}, out_data, e.data);
          check({tag, " last"}, out_last, e.last);
        end
      end else if (out_valid) begin
        stalled = 1'b1;
        held    = out_data;
        if (sb.size() > 0) check({tag, " stall src"}, out_src, sb[0].src);
      end
      acc = in_ready & in_valid;
      cyc++;
      @(posedge clk);
      #1;
      for (int i = 0; i < Port; i++) begin
        if (acc[i]) void'(pq[i].pop_front());
      end
      if (cyc == chg_cyc) cfg_weight[0] = chg_w0;
      out_ready = rpat[cyc % rpat.size()];
      drive();
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got %0d beats outstanding expected 0", tag, sb.size());
    end
    check({tag, " cycles"}, cyc, exp_cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish within time limit");
    $fatal(1);
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    out_ready  = 1'b0;
    in_valid   = '0;
    in_last    = '0;
    in_data    = '0;
    cfg_weight = {Port{4'd1}};

    // Combinational vectors, each applied right after a fresh reset (ptr -> port 0 first).
    tbl[0] = mkv(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0);
    tbl[1] = mkv(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0);
    tbl[2] = mkv(1'b0, 4'b1111, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b0001, 32'hC0DE0000);
    tbl[3] = mkv(1'b0, 4'b1110, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 4'b0010, 32'hC0DE0001);
    tbl[4] = mkv(1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1, 4'b1000, 4'b0000, 32'hC0DE0003);
    tbl[5] = mkv(1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 4'b0100, 32'hC0DE0002);
    tbl[6] = mkv(1'b0, 4'b1010, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 4'b0010, 32'hC0DE0001);
    for (int i = 0; i < Port; i++) in_data[i] = 32'hC0DE0000 | 32'(i);
    for (int t = 0; t < 7; t++) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = tbl[t].r;
      in_valid  = tbl[t].v;
      in_last   = tbl[t].l;
      out_ready = tbl[t].rdy;
      #2;
      check($sformatf("vec%0d out_valid", t), out_valid, tbl[t].ev);
      check($sformatf("vec%0d out_last", t), out_last, tbl[t].el);
      check($sformatf("vec%0d out_src", t), out_src, tbl[t].esrc);
      check($sformatf("vec%0d in_ready", t), in_ready, tbl[t].erdy);
      check($sformatf("vec%0d out_data", t), out_data, tbl[t].edata);
      rst = 1'b1;
    end

    // Equal weights, single-beat packets on every port: strict rotation, one beat per cycle.
    cfg_weight = {Port{4'd1}};
    rpat = '{1'b1};
    do_reset();
    for (int p = 0; p < Port; p++) for (int k = 0; k < 3; k++) load_pkt(p, k, 1);
    ord = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    expect_order();
    run("rotate", 40, 12, -1, 4'd0);

    // Four-beat packet on port 1 under alternating backpressure while port 2 waits.
    rpat = '{1'b1, 1'b0};
    do_reset();
    load_pkt(1, 0, 4);
    load_pkt(2, 0, 2);
    exp_pkt(1, 0, 4, 0);
    exp_pkt(2, 0, 2, 0);
    run("stall", 40, 11, -1, 4'd0);

    // Port 0 weight 3: three packets per turn.
    cfg_weight    = {Port{4'd1}};
    cfg_weight[0] = 4'd3;
    rpat = '{1'b1};
    do_reset();
    for (int k = 0; k < 6; k++) load_pkt(0, k, 1);
    for (int p = 1; p < Port; p++) for (int k = 0; k < 2; k++) load_pkt(p, k, 1);
    ord = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1, 2, 3};
    expect_order();
    run("weight3", 40, 12, -1, 4'd0);

    // Port 2 weight 0 acts as 1; port 0 weight drops 3->1 mid-turn, effective next turn.
    cfg_weight    = {Port{4'd1}};
    cfg_weight[0] = 4'd3;
    cfg_weight[2] = 4'd0;
    rpat = '{1'b1};
    do_reset();
    for (int k = 0; k < 6; k++) load_pkt(0, k, 1);
    for (int p = 1; p < Port; p++) for (int k = 0; k < 2; k++) load_pkt(p, k, 1);
    ord = '{0, 0, 0, 1, 2, 3, 0, 1, 2, 3, 0, 0};
    expect_order();
    run("wchange", 40, 12, 1, 4'd1);

    // Reset in the middle of a port 3 packet, then port 0 must win with no lock left.
    cfg_weight = {Port{4'd1}};
    rpat = '{1'b1};
    do_reset();
    load_pkt(3, 0, 3);
    exp_pkt(3, 0, 1, 0);
    sb[0].last = 1'b0;
    run("prereset", 10, 1, -1, 4'd0);
    rst = 1'b1;
    load_pkt(0, 0, 1);
    drive();
    #2;
    check("inreset out_valid", out_valid, 1'b0);
    check("inreset out_src", out_src, 4'b0000);
    check("inreset in_ready", in_ready, 4'b0000);
    check("inreset out_data", out_data, 32'h0);
    check("inreset out_last", out_last, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pkt(0, 0, 1, 0);
    exp_pkt(3, 0, 3, 1);
    run("postreset", 20, 3, -1, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
